// File: rtl/lcd_status_pkg.sv
// Shared definitions for the LCD status page: FSM states, ASCII codes,
// screen templates and the default busy-wait timeout.
package lcd_status_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SNAP,
        S_WRITE,
        S_UPDATE,
        S_WAIT
    } state_t;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_EQUAL = 8'h3D;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_A     = 8'h41;

    // Fixed text of each row; each field position holds a '0' digit that
    // is overridden by live snapshot data while writing.
    localparam logic [127:0] ROW0_TMPL = {"DIP", ASCII_EQUAL, "00", ASCII_SPACE,
                                          "DA", ASCII_EQUAL, "0", {5{ASCII_SPACE}}};
    localparam logic [127:0] ROW1_TMPL = {"A1", ASCII_EQUAL, "0", ASCII_SPACE,
                                          "A2", ASCII_EQUAL, "0", ASCII_SPACE,
                                          "AV", ASCII_EQUAL, "0", {2{ASCII_SPACE}}};
    localparam logic [255:0] SCREEN_TMPL = {ROW0_TMPL, ROW1_TMPL};

    // Linear character index (row*16 + col) of each data field.
    localparam logic [4:0] IDX_DIP_HI = 5'd4;
    localparam logic [4:0] IDX_DIP_LO = 5'd5;
    localparam logic [4:0] IDX_DA     = 5'd10;
    localparam logic [4:0] IDX_AD1    = 5'd19;
    localparam logic [4:0] IDX_AD2    = 5'd24;
    localparam logic [4:0] IDX_AV     = 5'd29;
    localparam logic [4:0] IDX_LAST   = 5'd31;

    // Character 0 sits in the MSB byte, so byte offset is 31-idx == ~idx.
    function automatic logic [7:0] template_char(input logic [4:0] idx);
        return SCREEN_TMPL[{~idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/lcd_status_hex2ascii.sv
// Hex nibble to upper-case ASCII digit.
module hex2ascii
    import lcd_status_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    // '0'..'9' for 0..9, 'A'..'F' for 10..15
    always_comb begin
        if (nibble < 4'd10) ascii = ASCII_ZERO + {4'h0, nibble};
        else                ascii = (ASCII_A - 8'd10) + {4'h0, nibble};
    end

endmodule

// File: rtl/lcd_status.sv
// Renders DIP / DA / AD-delay status onto a 2x16 character LCD buffer and
// requests a panel update whenever the displayed inputs change.
module lcd_status
    import lcd_status_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] DIP,
    input  logic [3:0] ad1_delay,
    input  logic [3:0] ad2_delay,
    input  logic [3:0] ad_valid_delay,
    input  logic       reader_da_start,
    output logic       lcd_row,
    output logic [3:0] lcd_col,
    output logic [7:0] lcd_char,
    output logic       lcd_we,
    output logic       lcd_update,
    input  logic       lcd_busy
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t         state, state_nxt;
    logic           first, first_nxt;
    logic [4:0]     idx, idx_nxt;
    logic [20:0]    snap;
    logic           snap_load;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic           seen_busy, seen_nxt;
    logic           row_nxt, we_nxt, upd_nxt;
    logic [3:0]     col_nxt;
    logic [7:0]     char_nxt;
    logic [20:0]    live;
    logic [3:0]     nib;
    logic           is_field;
    logic [7:0]     hex_char;

    assign live = {DIP, ad1_delay, ad2_delay, ad_valid_delay, reader_da_start};

    // Pick the snapshot nibble shown at the current index, if it is a field
    always_comb begin
        is_field = 1'b1;
        nib      = '0;
        case (idx)
            IDX_DIP_HI: nib = snap[20:17];
            IDX_DIP_LO: nib = snap[16:13];
            IDX_AD1:    nib = snap[12:9];
            IDX_AD2:    nib = snap[8:5];
            IDX_AV:     nib = snap[4:1];
            IDX_DA:     nib = {3'b000, snap[0]};
            default:    is_field = 1'b0;
        endcase
    end

    hex2ascii u_hex2ascii (
        .nibble (nib),
        .ascii  (hex_char)
    );

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_nxt = state;
        first_nxt = first;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        seen_nxt  = seen_busy;
        snap_load = 1'b0;
        we_nxt    = 1'b0;
        upd_nxt   = 1'b0;
        row_nxt   = lcd_row;
        col_nxt   = lcd_col;
        char_nxt  = lcd_char;
        case (state)
            S_IDLE: begin
                if (!lcd_busy && (first || (live != snap))) state_nxt = S_SNAP;
            end
            S_SNAP: begin
                snap_load = 1'b1;
                first_nxt = 1'b0;
                idx_nxt   = '0;
                state_nxt = S_WRITE;
            end
            S_WRITE: begin
                if (!lcd_busy) begin
                    we_nxt   = 1'b1;
                    row_nxt  = idx[4];
                    col_nxt  = idx[3:0];
                    char_nxt = is_field ? hex_char : template_char(idx);
                    if (idx == IDX_LAST) state_nxt = S_UPDATE;
                    else                 idx_nxt   = idx + 5'd1;
                end
            end
            S_UPDATE: begin
                if (!lcd_busy) begin
                    upd_nxt   = 1'b1;
                    cnt_nxt   = '0;
                    seen_nxt  = 1'b0;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // Once busy has been seen the timeout no longer applies;
                // only the falling edge of busy ends the wait.
                if (lcd_busy) begin
                    seen_nxt = 1'b1;
                end else if (seen_busy) begin
                    state_nxt = S_IDLE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath registers and registered LCD outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            first      <= 1'b1;
            idx        <= '0;
            snap       <= '0;
            cnt        <= '0;
            seen_busy  <= 1'b0;
            lcd_row    <= 1'b0;
            lcd_col    <= '0;
            lcd_char   <= ASCII_SPACE;
            lcd_we     <= 1'b0;
            lcd_update <= 1'b0;
        end else begin
            first      <= first_nxt;
            idx        <= idx_nxt;
            cnt        <= cnt_nxt;
            seen_busy  <= seen_nxt;
            lcd_row    <= row_nxt;
            lcd_col    <= col_nxt;
            lcd_char   <= char_nxt;
            lcd_we     <= we_nxt;
            lcd_update <= upd_nxt;
            if (snap_load) snap <= live;
        end
    end

endmodule

// File: tb/tb_lcd_status.sv
// Self-checking bench for lcd_status: every refresh is compared against a
// screen string built from the input values with plain string formatting.
module tb_lcd_status;

    localparam int unsigned TO = 255;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] dip;
    logic [3:0] ad1, ad2, adv;
    logic       da, busy;
    logic       lcd_row, lcd_we, lcd_update;
    logic [3:0] lcd_col;
    logic [7:0] lcd_char;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int upd_cnt = 0;
    int upd_cyc = 0;
    int first_we_cyc = 0;
    int last_upd_cyc = 0;
    logic [12:0] wq[$];
    int          wc[$];

    lcd_status #(.TIMEOUT(TO)) dut (
        .CLK             (clk),
        .RST             (rst_n),
        .DIP             (dip),
        .ad1_delay       (ad1),
        .ad2_delay       (ad2),
        .ad_valid_delay  (adv),
        .reader_da_start (da),
        .lcd_row         (lcd_row),
        .lcd_col         (lcd_col),
        .lcd_char        (lcd_char),
        .lcd_we          (lcd_we),
        .lcd_update      (lcd_update),
        .lcd_busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Record every write and update pulse as the panel would see them.
    always @(negedge clk) begin
        if (lcd_we) begin
            wq.push_back({lcd_row, lcd_col, lcd_char});
            wc.push_back(cyc);
        end
        if (lcd_update) begin
            upd_cnt++;
            upd_cyc = cyc;
        end
        if (lcd_we || lcd_update) check("we_upd_excl", {31'd0, lcd_we & lcd_update}, 0);
    end

    function automatic string hx(input int n);
        string d;
        d = "0123456789ABCDEF";
        return d.substr(n, n);
    endfunction

    // Expected 32-character screen for the current input values.
    function automatic string scr();
        return {"DIP=", hx(int'(dip[7:4])), hx(int'(dip[3:0])), " DA=", (da ? "1" : "0"), "     ",
                "A1=", hx(int'(ad1)), " A2=", hx(int'(ad2)), " AV=", hx(int'(adv)), "  "};
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_writes(input int n, input string tag);
        int t = 0;
        while (wq.size() < n && t < 2000) begin
            step();
            t++;
        end
        if (wq.size() < n) check({tag, "_wait_writes"}, wq.size(), n);
    endtask

    // Wait for the next update pulse and compare the 32 writes before it.
    task automatic expect_refresh(input string exp_s, input string tag);
        int u0 = upd_cnt;
        int t = 0;
        while (upd_cnt == u0 && t < 3000) begin
            step();
            t++;
        end
        check({tag, "_update"}, upd_cnt - u0, 1);
        check({tag, "_nwrites"}, wq.size(), 32);
        for (int k = 0; k < 32 && k < wq.size(); k++) begin
            logic [4:0] a;
            a = 5'(k);
            check($sformatf("%s_wr%0d", tag, k), {19'd0, wq[k]}, {19'd0, a, exp_s[k]});
        end
        if (wc.size() > 0) begin
            first_we_cyc = wc[0];
            check({tag, "_upd_after_last"}, upd_cyc - wc[wc.size()-1], 1);
        end
        last_upd_cyc = upd_cyc;
        wq.delete();
        wc.delete();
    endtask

    task automatic settle(input string tag);
        int u0 = upd_cnt;
        repeat (TO + 20) step();
        check({tag, "_no_writes"}, wq.size(), 0);
        check({tag, "_no_update"}, upd_cnt - u0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        string s_old;
        int ua;
        busy = 1'b0; dip = 8'h81; ad1 = 4'h2; ad2 = 4'h2; adv = 4'h0; da = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) step();
        check("rst_we",   {31'd0, lcd_we}, 0);
        check("rst_upd",  {31'd0, lcd_update}, 0);
        check("rst_char", {24'd0, lcd_char}, 32'h20);
        check("rst_row",  {31'd0, lcd_row}, 0);
        check("rst_col",  {28'd0, lcd_col}, 0);
        rst_n = 1'b1;

        // Boot refresh; update strobe follows the 32 writes back-to-back.
        expect_refresh(scr(), "boot");
        check("boot_span", last_upd_cyc - first_we_cyc, 32);
        settle("boot_settle");

        // Single field change: exactly one refresh.
        ad1 = 4'hF;
        expect_refresh(scr(), "ad1");
        settle("ad1_settle");

        // WAIT with busy never high: TIMEOUT cycles in WAIT, then IDLE, SNAP,
        // one WRITE cycle before the first registered strobe.
        dip = 8'h3C;
        expect_refresh(scr(), "dip");
        ua = last_upd_cyc;
        dip = 8'hA5;
        expect_refresh(scr(), "timeout");
        check("wait_timeout_gap", first_we_cyc - ua, TO + 3);

        // WAIT ended by busy high then low.
        ua = last_upd_cyc;
        busy = 1'b1;
        adv = 4'h9;
        repeat (3) step();
        busy = 1'b0;
        expect_refresh(scr(), "handshake");
        check("wait_busy_gap", first_we_cyc - ua, 7);

        // Busy stall of 5 cycles at index 10.
        ad2 = 4'hB;
        wait_writes(10, "stall");
        busy = 1'b1;
        repeat (5) step();
        busy = 1'b0;
        wait_writes(11, "stall");
        if (wc.size() >= 11) check("stall_gap", wc[10] - wc[9], 6);
        expect_refresh(scr(), "stall");

        // Input change mid-refresh shows up only in the following refresh.
        ad1 = 4'h3;
        s_old = scr();
        wait_writes(20, "da");
        da = ~da;
        expect_refresh(s_old, "da_old");
        expect_refresh(scr(), "da_new");

        // Reset mid-refresh drops strobes at once, then a full refresh.
        dip = 8'h00;
        wait_writes(17, "rst");
        rst_n = 1'b0;
        #1;
        check("midrst_we",  {31'd0, lcd_we}, 0);
        check("midrst_upd", {31'd0, lcd_update}, 0);
        repeat (2) step();
        wq.delete();
        wc.delete();
        rst_n = 1'b1;
        expect_refresh(scr(), "rst");

        // Randomized inputs, optionally with a busy stall during writing.
        for (int it = 0; it < 6; it++) begin
            logic [20:0] prev;
            prev = {dip, ad1, ad2, adv, da};
            dip = 8'($urandom); ad1 = 4'($urandom); ad2 = 4'($urandom);
            adv = 4'($urandom); da = 1'($urandom);
            if ({dip, ad1, ad2, adv, da} == prev) dip = dip ^ 8'h01;
            if ($urandom_range(0, 1) == 1) begin
                wait_writes(int'($urandom_range(1, 30)), "rnd");
                busy = 1'b1;
                repeat ($urandom_range(1, 4)) step();
                busy = 1'b0;
            end
            expect_refresh(scr(), $sformatf("rnd%0d", it));
        end
        settle("final");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lcd_status.md
LCD_STATUS -- requirements
Module: lcd_status

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum cycles to wait for lcd_busy to assert after an update pulse.
REQ-002 SHALL have ports:
- CLK, input, 1, single clock (clkcomm domain).
- RST, input, 1, asynchronous active-low reset.
- DIP, input, 8, DIP switch value.
- ad1_delay, input, 4, AD1 delay setting.
- ad2_delay, input, 4, AD2 delay setting.
- ad_valid_delay, input, 4, AD valid-delay setting.
- reader_da_start, input, 1, DA reader run flag.
- lcd_row, output, 1, character row (0/1).
- lcd_col, output, 4, character column (0..15).
- lcd_char, output, 8, ASCII code.
- lcd_we, output, 1, character write strobe.
- lcd_update, output, 1, one-cycle request to push the buffer to the panel.
- lcd_busy, input, 1, LCD driver busy.
REQ-003 SHALL have all inputs synchronous to CLK; no internal synchronisers.

Function
REQ-004 SHALL render a 2x16 display:
- Row 0: "DIP=HH DA=B" followed by 5 spaces. HH is DIP in upper-case hex, MSB nibble first. B is '1'/'0' from reader_da_start.
- Row 1: "A1=H A2=H AV=H" followed by 2 spaces, from ad1_delay, ad2_delay, ad_valid_delay.
REQ-005 SHALL convert hex nibble n to ASCII as 0x30+n for n<10 and 0x37+n otherwise.
REQ-006 SHALL use states IDLE, SNAP, WRITE, UPDATE, WAIT.
REQ-007 IDLE: SHALL go to SNAP when lcd_busy=0 and either the first-refresh flag is set or any live input differs from the snapshot.
REQ-008 SNAP: SHALL capture all 21 input bits into the snapshot registers, clear the first-refresh flag, zero the char index, and go to WRITE.
REQ-009 WRITE: SHALL emit one character per cycle while lcd_busy=0, in order row 0 col 0..15 then row 1 col 0..15 (index 0..31).
- lcd_row = index[4]; lcd_col = index[3:0].
- Characters come from the snapshot only.
REQ-010 WRITE: SHALL hold lcd_we=0 and the index while lcd_busy=1, and resume at the same index once lcd_busy=0.
REQ-011 SHALL go from WRITE to UPDATE after index 31 is written; the index SHALL NOT wrap back to 0 within a refresh.
REQ-012 UPDATE: SHALL assert lcd_update for exactly one cycle when lcd_busy=0, then go to WAIT.
REQ-013 WAIT: SHALL return to IDLE after observing lcd_busy=1 followed by lcd_busy=0, or after TIMEOUT cycles with lcd_busy never high.
REQ-014 SHALL NOT abort or restart a refresh when inputs change during SNAP..WAIT; the change SHALL be caught by the IDLE compare afterwards.
REQ-015 SHALL keep lcd_we and lcd_update mutually exclusive, and both 0 outside WRITE/UPDATE.
REQ-016 SHALL register lcd_row, lcd_col, lcd_char and lcd_we together, giving a one-cycle latency from index to strobe.
REQ-017 SHALL complete a refresh with no busy stalls in 1 (SNAP) + 32 + 1 write-drain + 1 (UPDATE) cycles, plus WAIT.

Reset
REQ-018 On RST=0, SHALL asynchronously set:
- state=IDLE, first-refresh flag=1, index=0.
- snapshot=0, WAIT counter=0.
- lcd_row=0, lcd_col=0, lcd_char=0x20, lcd_we=0, lcd_update=0.
REQ-019 Reset mid-refresh SHALL leave no strobe asserted; a full refresh SHALL start after RST deasserts and lcd_busy=0.

Structure
REQ-020 SHALL place in a shared package: the state encoding, ASCII constants (space, '=', '0', 'A'), the fixed template strings, and the TIMEOUT default.
REQ-021 SHALL use one sub-module, hex2ascii (4-bit in, 8-bit out, combinational); the rest stays in lcd_status.

Verification
REQ-022 Release reset with lcd_busy=0, DIP=0x81, delays 2/2/0, reader_da_start=0 -> 32 writes, row 0 "DIP=81 DA=0     ", row 1 "A1=2 A2=2 AV=0  ", then one lcd_update pulse.
REQ-023 Idle and settled, then set ad1_delay 2->0xF -> exactly one refresh, row 1 col 3 = 0x46 ('F'), other characters unchanged.
REQ-024 Hold lcd_busy=1 for 5 cycles at index 10 -> lcd_we=0 for those cycles, resume at row 0 col 10, no skipped or duplicated index.
REQ-025 Toggle reader_da_start at index 20 -> current refresh shows the old value; a second refresh follows and shows the new value.
REQ-026 Keep lcd_busy=0 after lcd_update -> return to IDLE after exactly TIMEOUT=255 cycles; static inputs -> no further writes.
REQ-027 Assert RST at index 17 -> lcd_we and lcd_update drop immediately; after release, a full refresh restarts from index 0.
